control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the existing datapath's control inputs. It replaces hand-sequenced bench stimulus with an opcode-decoding FSM.
- Sequences fetch (T0–T2), then per-opcode execute steps (T3–T7) for a load/store/ALU subset.
- Sits directly upstream of dataPath: consumes IR contents, produces every strobe the datapath samples.

Parameters:
- ALU_ADD, 4'd2, datapath ALU control code for add (fixed by the datapath).
- ALU_SUB, 4'd3, ALU control code for sub.
- ALU_AND, 4'd4, ALU control code for and.
- ALU_OR, 4'd5, ALU control code for or.

Ports:
- clk  in  1  system clock; state advances on the falling edge so strobes are stable at the datapath's rising edge.
- reset  in  1  synchronous, active-high, sampled on the falling edge of clk.
- ir  in  32  IRval from datapath; opcode is ir[31:27].
- PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write, IRin, Yin, IncPc, Cout, BAout, Rin, Rout, GRA, GRB, GRC  out  1 each  datapath strobes.
- mdr_read  out  2  MDR source: 00 bus, 01 memory, 10 immediate.
- control  out  4  ALU operation code.
- run  out  1  high while executing; low after halt.
- illegal_op  out  1  sticky flag: an undefined opcode was decoded.

Behaviour:
- State register only; all strobes decode combinationally from state, plus ir in T3–T7.
- Any strobe not listed for a state is 0.
- Reset:
  - While reset is high at a falling edge, the next state is RST.
  - In RST all strobes are 0, mdr_read=00, control=0, run=1, illegal_op=0.
  - RST→T0 on the next edge.
  - Reset mid-instruction aborts immediately; no partial write or Rin is asserted after RST.
- Fetch:
  - T0: PCout, MARin, IncPc, Zlowin.
  - T1: Zlowout, PCin, read, mdr_read=01, MDRin.
  - T2: MDRout, IRin.
- Decode: ir is valid from T3 onward and is held by the datapath IR (IRin=0) until the next T2.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=01001, or=01010, addi=01011, nop=11010, halt=11011.
- ld:
  - T3: GRB, BAout, Yin.
  - T4: Cout, control=ALU_ADD, Zlowin.
  - T5: Zlowout, MARin.
  - T6: read, mdr_read=01, MDRin.
  - T7: MDRout, GRA, Rin.
  - T7→T0.
- ldi:
  - T3: GRB, BAout, Yin.
  - T4: Cout, control=ALU_ADD, Zlowin.
  - T5: Zlowout, GRA, Rin.
  - T5→T0.
- st:
  - T3–T5 as ld.
  - T6: GRA, Rout, mdr_read=00, MDRin.
  - T7: write.
  - T7→T0.
- add/sub/and/or:
  - T3: GRB, Rout, Yin.
  - T4: GRC, Rout, control=ALU_xxx, Zlowin.
  - T5: Zlowout, GRA, Rin.
  - T5→T0.
- addi:
  - T3: GRB, Rout, Yin.
  - T4: Cout, control=ALU_ADD, Zlowin.
  - T5: Zlowout, GRA, Rin.
  - T5→T0.
- nop: T3 asserts nothing; T3→T0.
- halt:
  - T3→HALT.
  - HALT: all strobes 0, run=0; it is absorbing until reset.
- Undefined opcode: behaves as nop and sets illegal_op (sticky until reset).
- Exclusivity invariants, checked in every state:
  - At most one bus driver among PCout, Zlowout, MDRout, Cout, BAout, Rout.
  - read and write are never both 1.

Decomposition:
- Package control_pkg holds:
  - state enumeration (RST, T0–T7, HALT);
  - opcode localparams;
  - ALU code defaults;
  - mdr_read source encodings.
- No sub-module: a single FSM with one combinational output decoder.

Test Plan:
- Reset 2 cycles, release -> RST then T0; T0 strobes exactly PCout, MARin, IncPc, Zlowin; run=1, illegal_op=0.
- ir=0x08800005 (ldi r1,5) -> T3 GRB+BAout+Yin; T4 Cout+control=2+Zlowin; T5 Zlowout+GRA+Rin; next state T0 (instruction takes 6 cycles).
- ir=0x19890000 (add r3,r1,r2) -> T4 GRC+Rout+control=2; T5 GRA+Rin; no Cout at any step.
- st opcode 00010 -> T6 mdr_read=00 with MDRin+Rout+GRA; T7 write=1, read=0; 8 cycles total.
- ir=0xD8000000 (halt) -> HALT entered after T3, run=0, strobes stay 0 for 20 cycles; reset returns to T0.
- Reset asserted during ld T5 -> RST on the next edge, no read/Rin follows. Separately, opcode 11111 -> nop path with illegal_op=1, held until reset.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: shared state encoding, opcodes, ALU codes and MDR source selects for the control sequencer
package control_pkg;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd3;
   localparam logic [3:0] ALU_AND = 4'd4;
   localparam logic [3:0] ALU_OR  = 4'd5;

   localparam logic [1:0] MDR_BUS = 2'b00;
   localparam logic [1:0] MDR_MEM = 2'b01;
   localparam logic [1:0] MDR_IMM = 2'b10;

   function automatic logic [3:0] alu_code(input logic [4:0] op);
      return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_ADD;
   endfunction

endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute FSM producing every datapath strobe from state and IR opcode
module control_sequencer
   import control_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        MARin,
   output logic        Zlowin,
   output logic        PCin,
   output logic        MDRin,
   output logic        read,
   output logic        write,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPc,
   output logic        Cout,
   output logic        BAout,
   output logic        Rin,
   output logic        Rout,
   output logic        GRA,
   output logic        GRB,
   output logic        GRC,
   output logic [1:0]  mdr_read,
   output logic [3:0]  control,
   output logic        run,
   output logic        illegal_op
);

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [4:0] op;
   logic       unused_ir;
   logic       is_ld, is_ldi, is_st, is_alu, is_addi, is_nop, is_halt, is_mem, is_base, is_legal;

   assign op        = ir[31:27];
   assign unused_ir = ^ir[26:0];
   assign is_ld     = op == OP_LD;
   assign is_ldi    = op == OP_LDI;
   assign is_st     = op == OP_ST;
   assign is_alu    = op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR;
   assign is_addi   = op == OP_ADDI;
   assign is_nop    = op == OP_NOP;
   assign is_halt   = op == OP_HALT;
   assign is_mem    = is_ld || is_st;
   assign is_base   = is_mem || is_ldi;
   assign is_legal  = is_base || is_alu || is_addi || is_nop || is_halt;

   // next state: linear fetch, opcode-dependent execute length, undefined opcodes retire like nop
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_RST: state_d = S_T0;
         S_T0:  state_d = S_T1;
         S_T1:  state_d = S_T2;
         S_T2:  state_d = S_T3;
         S_T3: begin
            state_d   = is_halt ? S_HALT : (is_nop || !is_legal) ? S_T0 : S_T4;
            illegal_d = illegal_q || !is_legal;
         end
         S_T4:  state_d = S_T5;
         S_T5:  state_d = is_mem ? S_T6 : S_T0;
         S_T6:  state_d = S_T7;
         S_T7:  state_d = S_T0;
         default: state_d = S_HALT;
      endcase
   end

   // state register on the falling edge so strobes settle before the datapath's rising edge
   always_ff @(negedge clk) begin
      if (reset) begin
         state_q   <= S_RST;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // output decode: everything defaults low, each state raises only its own strobes
   always_comb begin
      {PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write, IRin} = '0;
      {Yin, IncPc, Cout, BAout, Rin, Rout, GRA, GRB, GRC} = '0;
      mdr_read   = MDR_BUS;
      control    = 4'd0;
      run        = state_q != S_HALT;
      illegal_op = illegal_q;
      case (state_q)
         S_T0: {PCout, MARin, IncPc, Zlowin} = '1;
         S_T1: begin
            {Zlowout, PCin, read, MDRin} = '1;
            mdr_read = MDR_MEM;
         end
         S_T2: {MDRout, IRin} = '1;
         S_T3: begin
            GRB   = is_base || is_alu || is_addi;
            Yin   = is_base || is_alu || is_addi;
            BAout = is_base;
            Rout  = is_alu || is_addi;
         end
         S_T4: begin
            Zlowin  = 1'b1;
            Cout    = !is_alu;
            GRC     = is_alu;
            Rout    = is_alu;
            control = alu_code(is_alu ? op : OP_ADD);
         end
         S_T5: begin
            Zlowout = 1'b1;
            MARin   = is_mem;
            GRA     = !is_mem;
            Rin     = !is_mem;
         end
         S_T6: begin
            MDRin    = 1'b1;
            read     = is_ld;
            mdr_read = is_ld ? MDR_MEM : MDR_BUS;
            GRA      = !is_ld;
            Rout     = !is_ld;
         end
         S_T7: begin
            MDRout = is_ld;
            GRA    = is_ld;
            Rin    = is_ld;
            write  = !is_ld;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random instruction streams checked against a per-instruction strobe table
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ir;
   logic PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write, IRin;
   logic Yin, IncPc, Cout, BAout, Rin, Rout, GRA, GRB, GRC, run, illegal_op;
   logic [1:0] mdr_read;
   logic [3:0] control;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .reset(reset), .ir(ir),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zlowin(Zlowin),
      .PCin(PCin), .MDRin(MDRin), .read(read), .write(write), .IRin(IRin), .Yin(Yin),
      .IncPc(IncPc), .Cout(Cout), .BAout(BAout), .Rin(Rin), .Rout(Rout), .GRA(GRA),
      .GRB(GRB), .GRC(GRC), .mdr_read(mdr_read), .control(control), .run(run),
      .illegal_op(illegal_op)
   );

   localparam int P_PCOUT = 26, P_ZLOWOUT = 25, P_MDROUT = 24, P_MARIN = 23, P_ZLOWIN = 22;
   localparam int P_PCIN = 21, P_MDRIN = 20, P_READ = 19, P_WRITE = 18, P_IRIN = 17, P_YIN = 16;
   localparam int P_INCPC = 15, P_COUT = 14, P_BAOUT = 13, P_RIN = 12, P_ROUT = 11;
   localparam int P_GRA = 10, P_GRB = 9, P_GRC = 8, P_RUN = 1, P_ILL = 0;

   logic [26:0] obs;
   assign obs = {PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write, IRin, Yin,
                 IncPc, Cout, BAout, Rin, Rout, GRA, GRB, GRC, mdr_read, control, run, illegal_op};

   int          nchecks = 0;
   int          nerr = 0;
   bit          ill = 0;
   logic [26:0] steps[$];

   function automatic logic [26:0] b(int p);
      return 27'(1) << p;
   endfunction

   function automatic logic [26:0] ctl(int c);
      return 27'(c) << 2;
   endfunction

   function automatic logic [26:0] mdr(int m);
      return 27'(m) << 6;
   endfunction

   function automatic logic [26:0] cur();
      return b(P_RUN) | (ill ? b(P_ILL) : 27'd0);
   endfunction

   function automatic bit legal(logic [4:0] op);
      return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd26, 5'd27};
   endfunction

   task automatic plan(logic [4:0] op);
      logic [26:0] a0 = b(P_GRB) | b(P_BAOUT) | b(P_YIN);
      logic [26:0] a1 = b(P_COUT) | ctl(2) | b(P_ZLOWIN);
      logic [26:0] r0 = b(P_GRB) | b(P_ROUT) | b(P_YIN);
      logic [26:0] wb = b(P_ZLOWOUT) | b(P_GRA) | b(P_RIN);
      logic [26:0] ma = b(P_ZLOWOUT) | b(P_MARIN);
      int alu = op == 5'd3 ? 2 : op == 5'd4 ? 3 : op == 5'd9 ? 4 : 5;
      case (op)
         5'd0:  steps = '{a0, a1, ma, b(P_READ) | mdr(1) | b(P_MDRIN), b(P_MDROUT) | b(P_GRA) | b(P_RIN)};
         5'd1:  steps = '{a0, a1, wb};
         5'd2:  steps = '{a0, a1, ma, b(P_GRA) | b(P_ROUT) | mdr(0) | b(P_MDRIN), b(P_WRITE)};
         5'd3, 5'd4, 5'd9, 5'd10:
                steps = '{r0, b(P_GRC) | b(P_ROUT) | ctl(alu) | b(P_ZLOWIN), wb};
         5'd11: steps = '{r0, a1, wb};
         default: steps = '{27'd0};
      endcase
   endtask

   task automatic chk(string tag, logic [26:0] e);
      nchecks++;
      assert (obs === e) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
      nchecks++;
      assert ($countones({PCout, Zlowout, MDRout, Cout, BAout, Rout}) <= 1 && !(read && write)) else begin
         nerr++;
         $error("FAIL %s-excl observed drivers=%b rd=%b wr=%b expected <=1 driver and not rd&wr",
                tag, {PCout, Zlowout, MDRout, Cout, BAout, Rout}, read, write);
      end
   endtask

   task automatic cycle(string tag, logic [26:0] e);
      @(posedge clk);
      chk(tag, e);
   endtask

   task automatic run_instr(string tag, logic [31:0] w, int abort_k = -1);
      cycle({tag, "-T0"}, cur() | b(P_PCOUT) | b(P_MARIN) | b(P_INCPC) | b(P_ZLOWIN));
      ir = w;
      plan(w[31:27]);
      cycle({tag, "-T1"}, cur() | b(P_ZLOWOUT) | b(P_PCIN) | b(P_READ) | mdr(1) | b(P_MDRIN));
      cycle({tag, "-T2"}, cur() | b(P_MDROUT) | b(P_IRIN));
      for (int k = 0; k < steps.size(); k++) begin
         cycle($sformatf("%s-T%0d", tag, k + 3), cur() | steps[k]);
         if (k == abort_k) begin
            reset = 1'b1;
            ill   = 1'b0;
            cycle({tag, "-RST"}, cur());
            reset = 1'b0;
            return;
         end
      end
      if (!legal(w[31:27])) ill = 1'b1;
   endtask

   initial begin
      logic [4:0] op;
      logic [4:0] ops[9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd26};
      reset = 1'b1;
      ir    = 32'h0;
      @(posedge clk);
      cycle("rst1", cur());
      cycle("rst2", cur());
      reset = 1'b0;
      run_instr("ldi", 32'h08800005);
      run_instr("add", 32'h19890000);
      run_instr("st", 32'h10800010);
      run_instr("ld", 32'h00800004);
      run_instr("bad", 32'hF8000000);
      run_instr("nop", 32'hD0000000);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            do op = 5'($urandom_range(0, 31)); while (legal(op));
         end else begin
            op = ops[$urandom_range(0, 8)];
         end
         run_instr($sformatf("rnd%0d", i), {op, 27'($urandom)});
      end
      run_instr("ld-abort", 32'h00800004, 2);
      run_instr("halt", 32'hD8000000);
      repeat (20) cycle("halt-idle", cur() & ~b(P_RUN));
      reset = 1'b1;
      ill   = 1'b0;
      cycle("halt-rst", cur());
      reset = 1'b0;
      run_instr("post", 32'h08800005);
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
